// File: rtl/aurora_link_sequencer_pkg.sv
// Shared state encodings and output vectors for the Aurora link sequencer.
// CSR decode and the testbench read the same constants from here.
package auroraSeqPkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_RESET   = 3'd1,
        ST_PMA     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_WAIT    = 3'd4,
        ST_UP      = 3'd5,
        ST_FAULT   = 3'd6
    } seq_state_e;

    typedef struct packed {
        logic power_down;
        logic mgt_reset;
        logic pma_init;
        logic link_up;
        logic fault;
    } seq_out_t;

    localparam seq_out_t OFF_OUTPUTS = '{
        power_down: 1'b1,
        mgt_reset:  1'b1,
        pma_init:   1'b1,
        link_up:    1'b0,
        fault:      1'b0
    };

    function automatic seq_out_t outputs_for(input seq_state_e st);
        seq_out_t o;
        o = '0;
        case (st)
            ST_OFF:     o = OFF_OUTPUTS;
            ST_RESET:   o.mgt_reset = 1'b1;
            ST_PMA: begin
                o.mgt_reset = 1'b1;
                o.pma_init  = 1'b1;
            end
            ST_RELEASE: o.mgt_reset = 1'b1;
            ST_WAIT:    o = '0;
            ST_UP:      o.link_up = 1'b1;
            ST_FAULT: begin
                o.mgt_reset = 1'b1;
                o.pma_init  = 1'b1;
                o.fault     = 1'b1;
            end
            default:    o = OFF_OUTPUTS;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/aurora_link_sequencer_bit_sync.sv
// Two-flop synchronizer for a single asynchronous status bit.
module bitSync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_bit,
    output logic sync_bit
);

    (* ASYNC_REG = "TRUE" *) logic meta;
    (* ASYNC_REG = "TRUE" *) logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta   <= async_bit;
            sync_q <= meta;
        end
    end

    assign sync_bit = sync_q;

endmodule

// File: rtl/aurora_link_sequencer.sv
// Aurora transceiver bring-up sequencer: power-down, reset_pb / pma_init
// sequencing, channel-up timeout with bounded retries, and link-drop recovery.
module aurora_link_sequencer
    import auroraSeqPkg::*;
#(
    parameter int RESET_HOLD_CYCLES  = 128,
    parameter int PMA_INIT_CYCLES    = 1024,
    parameter int CHANNEL_UP_TIMEOUT = 16777215,
    parameter int MAX_RETRIES        = 8
) (
    input  logic        sysClk,
    input  logic        sysReset_n,
    input  logic        enable,
    input  logic        retryClear,
    input  logic        channelUp,
    input  logic        laneUp,
    input  logic        hardErr,
    input  logic        gtPllLock,
    output logic        mgtReset,
    output logic        mgtPmaInit,
    output logic        mgtPowerDown,
    output logic        linkUp,
    output logic        fault,
    output logic        laneUpSync,
    output logic [2:0]  state,
    output logic [3:0]  retryCount,
    output logic [15:0] dropCount
);

    localparam int MAX_A    = (RESET_HOLD_CYCLES > PMA_INIT_CYCLES) ? RESET_HOLD_CYCLES : PMA_INIT_CYCLES;
    localparam int MAX_HOLD = (MAX_A > CHANNEL_UP_TIMEOUT) ? MAX_A : CHANNEL_UP_TIMEOUT;
    localparam int TIMER_W  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    // Loads are N-1 so a hold of exactly 2^k cycles still fits in clog2 bits.
    localparam logic [TIMER_W-1:0] LOAD_RESET = TIMER_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOAD_PMA   = TIMER_W'(PMA_INIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOAD_WAIT  = TIMER_W'(CHANNEL_UP_TIMEOUT - 1);
    localparam logic [3:0]         RETRY_LIMIT = 4'(MAX_RETRIES);

    logic channel_up_s;
    logic lane_up_s;
    logic hard_err_s;
    logic pll_lock_s;

    seq_state_e         cur_state;
    seq_state_e         next_state;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_next;
    logic [3:0]         retry_cnt;
    logic [3:0]         retry_next;
    logic [15:0]        drop_cnt;
    logic [15:0]        drop_next;
    seq_out_t           out_q;
    seq_out_t           out_next;

    bitSync sync_channel_up (.clk(sysClk), .rst_n(sysReset_n), .async_bit(channelUp), .sync_bit(channel_up_s));
    bitSync sync_lane_up    (.clk(sysClk), .rst_n(sysReset_n), .async_bit(laneUp),    .sync_bit(lane_up_s));
    bitSync sync_hard_err   (.clk(sysClk), .rst_n(sysReset_n), .async_bit(hardErr),   .sync_bit(hard_err_s));
    bitSync sync_pll_lock   (.clk(sysClk), .rst_n(sysReset_n), .async_bit(gtPllLock), .sync_bit(pll_lock_s));

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            cur_state <= ST_OFF;
            timer     <= '0;
            retry_cnt <= '0;
            drop_cnt  <= '0;
            out_q     <= OFF_OUTPUTS;
        end else begin
            cur_state <= next_state;
            timer     <= timer_next;
            retry_cnt <= retry_next;
            drop_cnt  <= drop_next;
            out_q     <= out_next;
        end
    end

    always_comb begin
        next_state = cur_state;
        timer_next = (timer == '0) ? timer : timer - TIMER_W'(1);
        retry_next = retry_cnt;
        drop_next  = drop_cnt;
        if (!enable) begin
            next_state = ST_OFF;
            retry_next = '0;
        end else begin
            case (cur_state)
                ST_OFF:     next_state = ST_RESET;
                ST_RESET:   if (timer == '0) next_state = ST_PMA;
                ST_PMA:     if (timer == '0) next_state = ST_RELEASE;
                ST_RELEASE: if (timer == '0 && pll_lock_s) next_state = ST_WAIT;
                ST_WAIT: begin
                    // channel-up is tested first so it wins a tie with the timeout
                    if (channel_up_s) begin
                        next_state = ST_UP;
                        retry_next = '0;
                    end else if (timer == '0) begin
                        retry_next = retry_cnt + 4'd1;
                        next_state = (retry_next == RETRY_LIMIT) ? ST_FAULT : ST_RESET;
                    end
                end
                ST_UP: begin
                    retry_next = '0;
                    if (!channel_up_s || hard_err_s) begin
                        if (drop_cnt != 16'hFFFF) drop_next = drop_cnt + 16'd1;
                        next_state = ST_RESET;
                    end
                end
                ST_FAULT: begin
                    if (retryClear) begin
                        retry_next = '0;
                        next_state = ST_RESET;
                    end
                end
                default: next_state = ST_OFF;
            endcase
        end
        if (next_state != cur_state) begin
            case (next_state)
                ST_RESET, ST_RELEASE: timer_next = LOAD_RESET;
                ST_PMA:               timer_next = LOAD_PMA;
                ST_WAIT:              timer_next = LOAD_WAIT;
                default:              timer_next = '0;
            endcase
        end
    end

    always_comb begin
        out_next = outputs_for(next_state);
    end

    assign mgtPowerDown = out_q.power_down;
    assign mgtReset     = out_q.mgt_reset;
    assign mgtPmaInit   = out_q.pma_init;
    assign linkUp       = out_q.link_up;
    assign fault        = out_q.fault;
    assign laneUpSync   = lane_up_s;
    assign state        = cur_state;
    assign retryCount   = retry_cnt;
    assign dropCount    = drop_cnt;

endmodule

// File: tb/tb_aurora_link_sequencer.sv
// Directed testbench for aurora_link_sequencer with shortened timing parameters.
module tb_aurora_link_sequencer;
    import auroraSeqPkg::*;

    logic        sysClk = 1'b0;
    logic        sysReset_n;
    logic        enable;
    logic        retryClear;
    logic        channelUp;
    logic        laneUp;
    logic        hardErr;
    logic        gtPllLock;
    logic        mgtReset;
    logic        mgtPmaInit;
    logic        mgtPowerDown;
    logic        linkUp;
    logic        fault;
    logic        laneUpSync;
    logic [2:0]  state;
    logic [3:0]  retryCount;
    logic [15:0] dropCount;

    int total = 0;
    int bad   = 0;

    always #5 sysClk = ~sysClk;

    aurora_link_sequencer #(
        .RESET_HOLD_CYCLES (4),
        .PMA_INIT_CYCLES   (8),
        .CHANNEL_UP_TIMEOUT(100),
        .MAX_RETRIES       (3)
    ) dut (
        .sysClk      (sysClk),
        .sysReset_n  (sysReset_n),
        .enable      (enable),
        .retryClear  (retryClear),
        .channelUp   (channelUp),
        .laneUp      (laneUp),
        .hardErr     (hardErr),
        .gtPllLock   (gtPllLock),
        .mgtReset    (mgtReset),
        .mgtPmaInit  (mgtPmaInit),
        .mgtPowerDown(mgtPowerDown),
        .linkUp      (linkUp),
        .fault       (fault),
        .laneUpSync  (laneUpSync),
        .state       (state),
        .retryCount  (retryCount),
        .dropCount   (dropCount)
    );

    task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge sysClk);
            if (state === target) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        sysReset_n = 1'b0;
        enable = 1'b0; retryClear = 1'b0; channelUp = 1'b0;
        laneUp = 1'b0; hardErr = 1'b0; gtPllLock = 1'b0;
        repeat (3) @(negedge sysClk);
        total++; if (state !== ST_OFF) begin bad++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        total++; if ({mgtPowerDown, mgtReset, mgtPmaInit} !== 3'b111) begin bad++; $display("[TB] FAIL reset_mgt: got %b expected 111", {mgtPowerDown, mgtReset, mgtPmaInit}); end
        total++; if ({linkUp, fault} !== 2'b00) begin bad++; $display("[TB] FAIL reset_flags: got %b expected 00", {linkUp, fault}); end
        total++; if (retryCount !== 4'd0 || dropCount !== 16'd0) begin bad++; $display("[TB] FAIL reset_counts: got retry=%0d drop=%0d expected 0/0", retryCount, dropCount); end
        sysReset_n = 1'b1;
        laneUp = 1'b1;
        @(negedge sysClk);
        total++; if (laneUpSync !== 1'b0) begin bad++; $display("[TB] FAIL lane_sync_1: got %b expected 0", laneUpSync); end
        @(negedge sysClk);
        total++; if (laneUpSync !== 1'b1) begin bad++; $display("[TB] FAIL lane_sync_2: got %b expected 1", laneUpSync); end
        total++; if (state !== ST_OFF) begin bad++; $display("[TB] FAIL lane_no_effect: got %0d expected 0", state); end
    endtask

    task automatic test_bringup();
        logic [2:0] seq[$];
        logic [2:0] last;
        int  exp_seq[5] = '{1, 2, 3, 4, 5};
        int  pma_high = 0;
        int  latency  = -1;
        bit  up_seen  = 1'b0;
        bit  seq_ok;
        last = state;
        gtPllLock = 1'b1;
        enable = 1'b1;
        for (int cyc = 1; cyc <= 200 && !up_seen; cyc++) begin
            @(negedge sysClk);
            if (state !== last) begin seq.push_back(state); last = state; end
            if (mgtPmaInit === 1'b1 && state !== ST_OFF) pma_high++;
            if (linkUp === 1'b1) begin up_seen = 1'b1; latency = cyc - 30; end
            if (cyc == 30) channelUp = 1'b1;
        end
        total++; if (!up_seen) begin bad++; $display("[TB] FAIL bringup_timeout: got linkUp=0 expected 1 within 200 cycles"); end
        seq_ok = (seq.size() == 5);
        for (int i = 0; i < 5 && seq_ok; i++) if (seq[i] !== 3'(exp_seq[i])) seq_ok = 1'b0;
        total++; if (!seq_ok) begin bad++; $display("[TB] FAIL bringup_seq: got %0d transitions (first=%0d) expected 1,2,3,4,5", seq.size(), (seq.size() > 0) ? seq[0] : 3'd7); end
        total++; if (pma_high != 8) begin bad++; $display("[TB] FAIL bringup_pma_len: got %0d expected 8", pma_high); end
        total++; if (latency < 2 || latency > 3) begin bad++; $display("[TB] FAIL bringup_linkup_latency: got %0d expected 2..3", latency); end
    endtask

    task automatic test_link_drop();
        bit ok;
        total++; if (dropCount !== 16'd0) begin bad++; $display("[TB] FAIL drop_before: got %0d expected 0", dropCount); end
        channelUp = 1'b0;
        @(negedge sysClk);
        channelUp = 1'b1;
        wait_state(ST_RESET, 6, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL drop_to_reset: got state=%0d expected 1", state); end
        total++; if (dropCount !== 16'd1) begin bad++; $display("[TB] FAIL drop_count: got %0d expected 1", dropCount); end
        total++; if (linkUp !== 1'b0) begin bad++; $display("[TB] FAIL drop_linkup: got %b expected 0", linkUp); end
        wait_state(ST_UP, 100, ok);
        total++; if (!ok || linkUp !== 1'b1) begin bad++; $display("[TB] FAIL drop_recover: got state=%0d linkUp=%b expected 5/1", state, linkUp); end
    endtask

    task automatic test_timeout_fault();
        int  wait_len[$];
        int  retry_seen[$];
        int  run = 0;
        bit  reached = 1'b0;
        bit  ok;
        channelUp = 1'b0;
        for (int cyc = 0; cyc < 1500 && !reached; cyc++) begin
            @(negedge sysClk);
            if (state === ST_WAIT) run++;
            else if (run > 0) begin
                wait_len.push_back(run);
                retry_seen.push_back(int'(retryCount));
                run = 0;
            end
            if (state === ST_FAULT) reached = 1'b1;
        end
        total++; if (!reached) begin bad++; $display("[TB] FAIL timeout_reach_fault: got state=%0d expected 6", state); end
        ok = (wait_len.size() == 3);
        for (int i = 0; i < 3 && ok; i++) if (wait_len[i] != 100) ok = 1'b0;
        total++; if (!ok) begin bad++; $display("[TB] FAIL timeout_wait_len: got %0d waits (first=%0d) expected 3 x 100", wait_len.size(), (wait_len.size() > 0) ? wait_len[0] : -1); end
        ok = (retry_seen.size() == 3);
        for (int i = 0; i < 3 && ok; i++) if (retry_seen[i] != i + 1) ok = 1'b0;
        total++; if (!ok) begin bad++; $display("[TB] FAIL timeout_retry_seq: got %0d values (last=%0d) expected 1,2,3", retry_seen.size(), (retry_seen.size() > 0) ? retry_seen[$] : -1); end
        total++; if (fault !== 1'b1 || {mgtReset, mgtPmaInit} !== 2'b11) begin bad++; $display("[TB] FAIL fault_outputs: got fault=%b rst/pma=%b expected 1/11", fault, {mgtReset, mgtPmaInit}); end
        total++; if (dropCount !== 16'd2) begin bad++; $display("[TB] FAIL timeout_dropcount: got %0d expected 2", dropCount); end
        repeat (5) @(negedge sysClk);
        total++; if (state !== ST_FAULT) begin bad++; $display("[TB] FAIL fault_sticky: got %0d expected 6", state); end
        retryClear = 1'b1;
        @(negedge sysClk);
        retryClear = 1'b0;
        total++; if (state !== ST_RESET || retryCount !== 4'd0) begin bad++; $display("[TB] FAIL retry_clear: got state=%0d retry=%0d expected 1/0", state, retryCount); end
        total++; if (fault !== 1'b0) begin bad++; $display("[TB] FAIL retry_clear_fault: got %b expected 0", fault); end
    endtask

    task automatic test_disable();
        bit ok;
        wait_state(ST_WAIT, 40, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL disable_reach_wait: got state=%0d expected 4", state); end
        wait_state(ST_RESET, 120, ok);
        total++; if (!ok || retryCount !== 4'd1) begin bad++; $display("[TB] FAIL disable_first_retry: got state=%0d retry=%0d expected 1/1", state, retryCount); end
        wait_state(ST_PMA, 10, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL disable_reach_pma: got state=%0d expected 2", state); end
        repeat (3) @(negedge sysClk);
        enable = 1'b0;
        @(negedge sysClk);
        total++; if (state !== ST_OFF) begin bad++; $display("[TB] FAIL disable_state: got %0d expected 0", state); end
        total++; if ({mgtPowerDown, mgtReset, mgtPmaInit} !== 3'b111) begin bad++; $display("[TB] FAIL disable_mgt: got %b expected 111", {mgtPowerDown, mgtReset, mgtPmaInit}); end
        total++; if (retryCount !== 4'd0 || dropCount !== 16'd2) begin bad++; $display("[TB] FAIL disable_counts: got retry=%0d drop=%0d expected 0/2", retryCount, dropCount); end
        repeat (3) @(negedge sysClk);
        total++; if (state !== ST_OFF) begin bad++; $display("[TB] FAIL disable_hold: got %0d expected 0", state); end
    endtask

    task automatic test_pll_lock();
        bit ok;
        int stuck = 0;
        int lat = -1;
        gtPllLock = 1'b0;
        channelUp = 1'b1;
        repeat (3) @(negedge sysClk);
        enable = 1'b1;
        wait_state(ST_RELEASE, 30, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL pll_reach_release: got state=%0d expected 3", state); end
        for (int i = 0; i < 50; i++) begin
            @(negedge sysClk);
            if (state !== ST_RELEASE) stuck++;
        end
        total++; if (stuck != 0) begin bad++; $display("[TB] FAIL pll_hold_release: got %0d cycles outside 3 expected 0", stuck); end
        gtPllLock = 1'b1;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            @(negedge sysClk);
            if (state === ST_WAIT) lat = k;
        end
        total++; if (lat < 2 || lat > 3) begin bad++; $display("[TB] FAIL pll_wait_latency: got %0d expected 2..3", lat); end
        wait_state(ST_UP, 10, ok);
        total++; if (!ok || retryCount !== 4'd0) begin bad++; $display("[TB] FAIL pll_reach_up: got state=%0d retry=%0d expected 5/0", state, retryCount); end
    endtask

    task automatic test_async_reset();
        bit ok;
        channelUp = 1'b0;
        @(negedge sysClk);
        channelUp = 1'b1;
        wait_state(ST_RESET, 6, ok);
        wait_state(ST_UP, 60, ok);
        total++; if (!ok || dropCount !== 16'd3) begin bad++; $display("[TB] FAIL drop_pulse_3: got state=%0d drop=%0d expected 5/3", state, dropCount); end
        hardErr = 1'b1;
        @(negedge sysClk);
        hardErr = 1'b0;
        wait_state(ST_RESET, 6, ok);
        total++; if (!ok || dropCount !== 16'd4) begin bad++; $display("[TB] FAIL hard_err_drop: got state=%0d drop=%0d expected 1/4", state, dropCount); end
        wait_state(ST_UP, 60, ok);
        channelUp = 1'b0;
        wait_state(ST_WAIT, 40, ok);
        total++; if (!ok || dropCount !== 16'd5) begin bad++; $display("[TB] FAIL areset_precond: got state=%0d drop=%0d expected 4/5", state, dropCount); end
        #2;
        sysReset_n = 1'b0;
        #1;
        total++; if (state !== ST_OFF) begin bad++; $display("[TB] FAIL areset_state: got %0d expected 0", state); end
        total++; if ({mgtPowerDown, mgtReset, mgtPmaInit} !== 3'b111 || {linkUp, fault} !== 2'b00) begin bad++; $display("[TB] FAIL areset_outputs: got %b/%b expected 111/00", {mgtPowerDown, mgtReset, mgtPmaInit}, {linkUp, fault}); end
        total++; if (dropCount !== 16'd0 || retryCount !== 4'd0) begin bad++; $display("[TB] FAIL areset_counts: got drop=%0d retry=%0d expected 0/0", dropCount, retryCount); end
        total++; if (laneUpSync !== 1'b0) begin bad++; $display("[TB] FAIL areset_sync: got %b expected 0", laneUpSync); end
        @(negedge sysClk);
        sysReset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_link_drop();
        test_timeout_fault();
        test_disable();
        test_pll_lock();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/aurora_link_sequencer.md
AURORA_LINK_SEQUENCER -- requirements
Module: aurora_link_sequencer

Interface
REQ-001 Parameter RESET_HOLD_CYCLES, default 128: sysClk cycles reset_pb is held around pma_init.
REQ-002 Parameter PMA_INIT_CYCLES, default 1024: sysClk cycles pma_init is held high.
REQ-003 Parameter CHANNEL_UP_TIMEOUT, default 2^24-1: sysClk cycles to wait for channel_up before retry.
REQ-004 Parameter MAX_RETRIES, default 8: consecutive failed attempts before FAULT; range 1..15.
REQ-005 Port sysClk input 1: sole clock; all state updates on its rising edge.
REQ-006 Port sysReset_n input 1: asynchronous, active-low reset.
REQ-007 Ports enable input 1 and retryClear input 1: link enable, and single-cycle FAULT clear; both sysClk-domain.
REQ-008 Ports channelUp, laneUp, hardErr, gtPllLock input 1 each: Aurora status, asynchronous to sysClk.
REQ-009 Ports mgtReset, mgtPmaInit, mgtPowerDown output 1 each: drive Aurora reset_pb, pma_init, power_down.
REQ-010 Ports linkUp and fault output 1 each: link-up indication and terminal-fault indication.
REQ-011 Ports state output 3, retryCount output 4, dropCount output 16: status for CSR readback.

Function
REQ-012 The block SHALL pass each of channelUp, laneUp, hardErr and gtPllLock through a 2-FF synchronizer (ASYNC_REG); all decisions use synchronized values (2-cycle latency).
REQ-013 States and encodings SHALL be OFF=0, RESET=1, PMA=2, RELEASE=3, WAIT=4, UP=5, FAULT=6; state output is the current encoding.
REQ-014 OFF: mgtPowerDown=1, mgtReset=1, mgtPmaInit=1; enable=1 -> RESET.
REQ-015 RESET: mgtReset=1, mgtPmaInit=0, mgtPowerDown=0; after exactly RESET_HOLD_CYCLES cycles -> PMA.
REQ-016 PMA: mgtReset=1, mgtPmaInit=1; after exactly PMA_INIT_CYCLES cycles -> RELEASE.
REQ-017 RELEASE: mgtReset=1, mgtPmaInit=0; exit to WAIT only when RESET_HOLD_CYCLES have elapsed AND synchronized gtPllLock=1; otherwise remain.
REQ-018 WAIT: mgtReset=0, mgtPmaInit=0; synchronized channelUp=1 -> UP; timer reaching CHANNEL_UP_TIMEOUT first -> retryCount+1, then FAULT if the new value equals MAX_RETRIES, else RESET.
REQ-019 If channelUp rises in the same cycle the timeout expires, UP SHALL win.
REQ-020 UP: linkUp=1, retryCount cleared to 0; synchronized channelUp=0 or hardErr=1 -> dropCount+1 (saturating at 0xFFFF) and -> RESET.
REQ-021 FAULT: fault=1, mgtReset=1, mgtPmaInit=1; retryClear=1 -> retryCount=0 and -> RESET.
REQ-022 enable=0 SHALL force OFF on the next edge from any state, with highest priority; it clears retryCount but not dropCount.
REQ-023 One down-counter SHALL be shared by all timed states; it is reloaded on every state entry.
REQ-024 Counter width SHALL be the clog2 of the largest timing parameter.
REQ-025 All outputs SHALL be registered and change together with the state transition; no combinational input-to-output path.
REQ-026 laneUp SHALL be synchronized and exported for debug only; it does not affect transitions.

Reset
REQ-027 While sysReset_n=0: state=OFF, mgtPowerDown=1, mgtReset=1, mgtPmaInit=1, linkUp=0, fault=0, retryCount=0, dropCount=0, synchronizers=0, timer=0.
REQ-028 Reset asserted mid-sequence SHALL take effect immediately (asynchronously), with no completion of the current hold.

Structure
REQ-029 State encodings and the OFF-state output vector SHALL live in a shared package, auroraSeqPkg, so CSR decode and testbench use the same constants.
REQ-030 The 2-FF synchronizer SHALL be a single reusable sub-module, bitSync, instantiated four times.

Verification (RESET_HOLD_CYCLES=4, PMA_INIT_CYCLES=8, CHANNEL_UP_TIMEOUT=100, MAX_RETRIES=3)
REQ-031 Nominal bring-up: enable=1, gtPllLock=1, channelUp=1 from cycle 30.
  - Required: the state sequence 1,2,3,4,5.
  - Required: mgtPmaInit high for exactly 8 cycles.
  - Required: linkUp=1 two to three cycles after channelUp rises.
REQ-032 Timeout to FAULT: channelUp held 0.
  - Required: three WAIT timeouts of 100 cycles each.
  - Required: retryCount goes 1, 2, 3, then fault=1 and state=6.
  - Then: retryClear pulse -> state=1, retryCount=0.
REQ-033 Link drop: in UP, channelUp=0 for 1 cycle.
  - Required: dropCount goes 0 to 1.
  - Required: state=1 and linkUp=0.
  - Required: the sequence repeats to UP.
REQ-034 Disable mid-sequence: enable=0 during PMA.
  - Required: state=0 next cycle.
  - Required: all three mgt outputs=1.
  - Required: retryCount=0.
REQ-035 PLL not locked: gtPllLock=0 in RELEASE for 50 cycles.
  - Required: state remains 3.
  - Required: WAIT is entered 2-3 cycles after gtPllLock rises.
REQ-036 Async reset: sysReset_n low in WAIT with dropCount=5.
  - Required: all outputs take the REQ-027 values without a clock edge.
  - Required: dropCount=0.
